// File: rtl/prog_pkg.sv
// Shared types and helpers for the run-time loadable program memory.
// The loader FSM states and the byte-per-word arithmetic live here so the top and bench agree.
package prog_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ld_state_t;

  // Loader bytes needed to cover one (i_size+1)-bit instruction word.
  function automatic int bytes_per_word(input int i_size);
    return (i_size + 8) / 8;
  endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Instruction store: zero-filled at elaboration,
// one synchronous write port for the loader and one combinational read port for fetch.
module prog_mem_array #(
  parameter int    P_SIZE    = 6,
  parameter int    I_SIZE    = 24,
  parameter string INIT_FILE = "prog.hex"
) (
  input  logic              clk,
  input  logic              we,
  input  logic [P_SIZE-1:0] waddr,
  input  logic [I_SIZE:0]   wdata,
  input  logic [P_SIZE-1:0] raddr,
  output logic [I_SIZE:0]   rdata
);

  localparam int DEPTH = 1 << P_SIZE;

  logic [I_SIZE:0] mem [DEPTH];

  // Unwritten words stay 0, which the CPU decodes as NOP.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // NOTE: the array has no reset branch; RAM cannot be cleared in one cycle and the
  // program must survive nReset, so only the write-enable qualifies the store.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader_mem.sv
// Program memory with a byte-serial host loader: assembles little-endian bytes into
// instruction words, writes them to a wrapping address window and stalls the CPU meanwhile.
module prog_loader_mem
  import prog_pkg::*;
#(
  parameter int    P_SIZE    = 6,
  parameter int    I_SIZE    = 24,
  parameter string INIT_FILE = "prog.hex"
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [P_SIZE-1:0] address,
  output logic [I_SIZE:0]   instr,
  input  logic              ld_start,
  input  logic [P_SIZE-1:0] ld_base,
  input  logic [P_SIZE:0]   ld_len,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              cpu_hold
);

  localparam int BPW   = bytes_per_word(I_SIZE);
  localparam int BUF_W = 8 * BPW;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [P_SIZE:0]   ONE_WORD  = (P_SIZE + 1)'(1);

  ld_state_t         state;
  logic [P_SIZE-1:0] wr_addr;
  logic [P_SIZE:0]   words_left;
  logic [CNT_W-1:0]  byte_cnt;
  logic [BUF_W-1:0]  word_buf;
  logic              zero_done;
  logic              we;
  logic              take_byte;

  assign take_byte = (state == RECV) && ld_valid;

  // NOTE: every register here uses non-blocking assignment so each branch reads the
  // pre-edge values (e.g. words_left before its own decrement decides WRITE -> DONE).
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      wr_addr    <= '0;
      words_left <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      zero_done  <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start) begin
            if (ld_len != '0) begin
              state      <= RECV;
              wr_addr    <= ld_base;
              words_left <= ld_len;
              byte_cnt   <= '0;
            end else begin
              zero_done <= 1'b1;
            end
          end
        end
        RECV: begin
          if (take_byte) begin
            // Newest byte enters at the top, so byte 0 ends up in bits [7:0].
            word_buf <= (word_buf >> 8) | (BUF_W'(ld_data) << (BUF_W - 8));
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              state    <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          wr_addr    <= wr_addr + P_SIZE'(1);
          words_left <= words_left - ONE_WORD;
          state      <= (words_left == ONE_WORD) ? DONE : RECV;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign we       = (state == WRITE);
  assign ld_ready = (state == RECV);
  assign ld_busy  = (state == RECV) || (state == WRITE);
  assign cpu_hold = ld_busy;
  assign ld_done  = (state == DONE) || zero_done;

  // Byte lanes above the instruction MSB are assembled but never stored.
  generate
    if (BUF_W > I_SIZE + 1) begin : g_drop_hi
      logic unused_hi;
      assign unused_hi = ^word_buf[BUF_W-1:I_SIZE+1];
    end
  endgenerate

  prog_mem_array #(
    .P_SIZE   (P_SIZE),
    .I_SIZE   (I_SIZE),
    .INIT_FILE(INIT_FILE)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(wr_addr),
    .wdata(word_buf[I_SIZE:0]),
    .raddr(address),
    .rdata(instr)
  );

endmodule

// File: tb/tb_prog_loader_mem.sv
// Self-checking bench for prog_loader_mem: table-driven loads, hand-written corner
// sequences and randomized loads compared against an array model of program memory.
module tb_prog_loader_mem;

  localparam int P_SIZE = 6;
  localparam int I_SIZE = 24;
  localparam int DEPTH  = 1 << P_SIZE;
  localparam int BPW    = 4;

  typedef logic [7:0] byte_q_t [$];

  typedef struct packed {
    int dones;
    int done_cyc;
    int busy_cyc;
    int bubbles;
    int hold_err;
    int busy_err;
    int sent;
  } load_res_t;

  typedef struct {
    logic [5:0]  base;
    logic [6:0]  len;
    logic [7:0]  b [8];
    int          gap;
    logic [5:0]  chk0;
    logic [5:0]  chk1;
    logic [24:0] exp0;
    logic [24:0] exp1;
  } vec_t;

  logic              clk;
  logic              nReset;
  logic [P_SIZE-1:0] address;
  logic [I_SIZE:0]   instr;
  logic              ld_start;
  logic [P_SIZE-1:0] ld_base;
  logic [P_SIZE:0]   ld_len;
  logic [7:0]        ld_data;
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic              cpu_hold;

  logic [I_SIZE:0] ref_mem [DEPTH];
  int total;
  int bad;

  prog_loader_mem #(
    .P_SIZE   (P_SIZE),
    .I_SIZE   (I_SIZE),
    .INIT_FILE("")
  ) dut (
    .clk     (clk),
    .nReset  (nReset),
    .address (address),
    .instr   (instr),
    .ld_start(ld_start),
    .ld_base (ld_base),
    .ld_len  (ld_len),
    .ld_data (ld_data),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_busy (ld_busy),
    .ld_done (ld_done),
    .cpu_hold(cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Little-endian word k of a byte stream, truncated to the instruction width.
  function automatic logic [24:0] word_of(input byte_q_t bytes, input int k);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < BPW; j++) w = w | (32'(bytes[k*BPW + j]) << (8*j));
    return w[24:0];
  endfunction

  task automatic model_apply(input logic [5:0] base, input int len, input byte_q_t bytes);
    for (int k = 0; k < len; k++) ref_mem[6'(int'(base) + k)] = word_of(bytes, k);
  endtask

  task automatic scan(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      address = 6'(a);
      #1;
      check($sformatf("%s mem[%0d]", tag, a), 32'(instr), 32'(ref_mem[a]));
    end
  endtask

  task automatic rand_bytes(input int n, output byte_q_t q);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  // Runs one load; abort_at>=0 returns right after that many bytes were handed over.
  // The fetch address is left as set by the caller and watched for read-during-write.
  task automatic do_load(input logic [5:0] base, input logic [6:0] len, input byte_q_t bytes,
                         input int gap, input int pct, input bit junk, input int abort_at,
                         output load_res_t r);
    int idx, wait_left, k, total_b, post;
    bit pending;
    logic [24:0] pend_word;
    r = '0;
    r.done_cyc = -1;
    idx = 0; wait_left = 0; k = 0; post = 0; pending = 0; pend_word = '0;
    total_b = int'(len) * BPW;
    @(posedge clk); #1;
    ld_start = 1'b1; ld_base = base; ld_len = len;
    @(posedge clk); #1;
    ld_start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (wait_left > 0) begin
        ld_valid = 1'b0;
        wait_left--;
      end else begin
        ld_valid = (idx < total_b) && (int'($urandom_range(0, 99)) < pct);
      end
      ld_data  = (idx < total_b) ? bytes[idx] : 8'h00;
      ld_start = junk && (idx < total_b) && ($urandom_range(0, 3) == 0);
      ld_base  = 6'($urandom);
      ld_len   = 7'($urandom_range(0, 64));
      @(negedge clk);
      if (cpu_hold !== ld_busy) r.hold_err++;
      if (ld_busy) r.busy_cyc++;
      if (len != 0 && r.dones == 0 && !ld_done && !ld_busy) r.busy_err++;
      if (r.dones != 0 && ld_busy) r.busy_err++;
      if (ld_done) begin
        if (r.dones == 0) r.done_cyc = cyc;
        r.dones++;
      end
      if (ld_busy && !ld_ready) begin
        r.bubbles++;
        if (6'(int'(base) + k) == address) begin
          check("rdw_old", 32'(instr), 32'(ref_mem[address]));
          pending   = 1'b1;
          pend_word = word_of(bytes, k);
        end
        k++;
      end else if (pending) begin
        check("rdw_new", 32'(instr), 32'(pend_word));
        pending = 1'b0;
      end
      if (ld_valid && ld_ready) begin
        idx++;
        wait_left = gap;
        if (idx == abort_at) begin
          r.sent = idx;
          return;
        end
      end
      if (r.dones != 0) begin
        post++;
        if (post == 3) break;
      end
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    ld_start = 1'b0;
    r.sent   = idx;
  endtask

  task automatic check_load(input string tag, input load_res_t r, input int len);
    check({tag, " dones"},    32'(r.dones),    32'd1);
    check({tag, " bubbles"},  32'(r.bubbles),  32'(len));
    check({tag, " hold"},     32'(r.hold_err), 32'd0);
    check({tag, " busy"},     32'(r.busy_err), 32'd0);
    check({tag, " sent"},     32'(r.sent),     32'(len * BPW));
  endtask

  vec_t      vecs [4];
  load_res_t res;
  byte_q_t   q;

  initial begin
    total = 0;
    bad   = 0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    nReset = 1'b0; address = '0; ld_start = 1'b0; ld_base = '0; ld_len = '0;
    ld_data = '0; ld_valid = 1'b0;

    vecs[0] = '{6'd5,  7'd2, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88},
                0, 6'd5,  6'd6,  25'h0332211, 25'h0776655};
    vecs[1] = '{6'd20, 7'd2, '{8'hA1, 8'hB2, 8'hC3, 8'hD5, 8'hE6, 8'hF7, 8'h08, 8'h19},
                1, 6'd20, 6'd21, 25'h1C3B2A1, 25'h108F7E6};
    vecs[2] = '{6'd63, 7'd2, '{8'h01, 8'h02, 8'h03, 8'hFF, 8'h04, 8'h05, 8'h06, 8'hFE},
                0, 6'd63, 6'd0,  25'h1030201, 25'h0060504};
    vecs[3] = '{6'd10, 7'd1, '{8'h5A, 8'hA5, 8'h3C, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00},
                2, 6'd10, 6'd11, 25'h13CA55A, 25'h0000000};

    // Reset state and zero-filled image.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ld_ready", 32'(ld_ready), 32'd0);
    check("rst ld_busy",  32'(ld_busy),  32'd0);
    check("rst ld_done",  32'(ld_done),  32'd0);
    check("rst cpu_hold", 32'(cpu_hold), 32'd0);
    scan("init");
    @(negedge clk);
    nReset = 1'b1;

    // Directed table of loads with hand-computed words.
    for (int v = 0; v < 4; v++) begin
      q = {};
      for (int j = 0; j < 8; j++) q.push_back(vecs[v].b[j]);
      address = 6'(int'(vecs[v].base) + int'(vecs[v].len) - 1);
      do_load(vecs[v].base, vecs[v].len, q, vecs[v].gap, 100, 1'b0, -1, res);
      check_load($sformatf("vec%0d", v), res, int'(vecs[v].len));
      if (vecs[v].gap == 0) begin
        check($sformatf("vec%0d done_cyc", v), 32'(res.done_cyc), 32'(int'(vecs[v].len) * (BPW + 1)));
        check($sformatf("vec%0d busy_cyc", v), 32'(res.busy_cyc), 32'(int'(vecs[v].len) * (BPW + 1)));
      end
      address = vecs[v].chk0; #1;
      check($sformatf("vec%0d word0", v), 32'(instr), 32'(vecs[v].exp0));
      address = vecs[v].chk1; #1;
      check($sformatf("vec%0d word1", v), 32'(instr), 32'(vecs[v].exp1));
      model_apply(vecs[v].base, int'(vecs[v].len), q);
      scan($sformatf("vec%0d", v));
    end

    // Zero-length load: done on the next cycle, never busy, nothing written.
    q = {};
    address = 6'd7;
    do_load(6'd7, 7'd0, q, 0, 100, 1'b0, -1, res);
    check("len0 dones",    32'(res.dones),    32'd1);
    check("len0 done_cyc", 32'(res.done_cyc), 32'd0);
    check("len0 busy_cyc", 32'(res.busy_cyc), 32'd0);
    scan("len0");

    // Full-depth load rewrites every word exactly once, wrapping from a random base.
    rand_bytes(DEPTH * BPW, q);
    begin
      logic [5:0] b;
      b = 6'($urandom);
      address = b;
      do_load(b, 7'd64, q, 0, 100, 1'b0, -1, res);
      check_load("full", res, DEPTH);
      check("full done_cyc", 32'(res.done_cyc), 32'(DEPTH * (BPW + 1)));
      model_apply(b, DEPTH, q);
    end
    scan("full");

    // Reset after one and a half words: first word kept, second discarded.
    rand_bytes(2 * BPW, q);
    address = 6'd31;
    do_load(6'd30, 7'd2, q, 0, 100, 1'b0, 6, res);
    @(posedge clk); #2;
    nReset = 1'b0; ld_valid = 1'b0;
    #1;
    check("midrst ld_ready", 32'(ld_ready), 32'd0);
    check("midrst ld_busy",  32'(ld_busy),  32'd0);
    check("midrst ld_done",  32'(ld_done),  32'd0);
    check("midrst cpu_hold", 32'(cpu_hold), 32'd0);
    ref_mem[30] = word_of(q, 0);
    @(negedge clk);
    nReset = 1'b1;
    scan("midrst");
    rand_bytes(BPW, q);
    address = 6'd31;
    do_load(6'd31, 7'd1, q, 0, 100, 1'b0, -1, res);
    check_load("postrst", res, 1);
    check("postrst done_cyc", 32'(res.done_cyc), 32'(BPW + 1));
    model_apply(6'd31, 1, q);
    scan("postrst");

    // Randomized loads with throttled ld_valid and stray ld_start pulses.
    for (int it = 0; it < 20; it++) begin
      logic [5:0] b;
      int len, pct;
      bit junk;
      b    = 6'($urandom);
      len  = ($urandom_range(0, 9) == 0) ? DEPTH : int'($urandom_range(0, 5));
      pct  = (it % 3 == 0) ? 100 : ((it % 3 == 1) ? 60 : 30);
      junk = 1'($urandom);
      rand_bytes(len * BPW, q);
      address = 6'(int'(b) + int'($urandom_range(0, 3)));
      do_load(b, 7'(len), q, 0, pct, junk, -1, res);
      check_load($sformatf("rnd%0d", it), res, len);
      model_apply(b, len, q);
      scan($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
